// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the cache/memory subsystem
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    localparam logic GRANT_INSTR = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

endpackage

// File: rtl/cache_arbiter_perf.sv
// rtl/cache_arbiter_perf.sv - saturating grant/contention counters for cache_arbiter
module cache_arbiter_perf #(
    parameter int S_CNT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_grant_i,
    input  logic             d_grant_i,
    input  logic             contention_i,
    output logic [S_CNT-1:0] perf_i_grants_o,
    output logic [S_CNT-1:0] perf_d_grants_o,
    output logic [S_CNT-1:0] perf_contention_o
);

    logic [S_CNT-1:0] i_cnt_q, i_cnt_d;
    logic [S_CNT-1:0] d_cnt_q, d_cnt_d;
    logic [S_CNT-1:0] c_cnt_q, c_cnt_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        i_cnt_d = i_cnt_q;
        d_cnt_d = d_cnt_q;
        c_cnt_d = c_cnt_q;
        if (i_grant_i && (i_cnt_q != '1)) i_cnt_d = i_cnt_q + 1'b1;
        if (d_grant_i && (d_cnt_q != '1)) d_cnt_d = d_cnt_q + 1'b1;
        if (contention_i && (c_cnt_q != '1)) c_cnt_d = c_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_cnt_q <= '0;
            d_cnt_q <= '0;
            c_cnt_q <= '0;
        end else begin
            i_cnt_q <= i_cnt_d;
            d_cnt_q <= d_cnt_d;
            c_cnt_q <= c_cnt_d;
        end
    end

    assign perf_i_grants_o   = i_cnt_q;
    assign perf_d_grants_o   = d_cnt_q;
    assign perf_contention_o = c_cnt_q;

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin I/D cache line arbiter to the cacheline adaptor
// Optional perf counters: CACHE_ARB_PERF_EN
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int S_LINE = 256,
    parameter int S_ADDR = 32,
    parameter int S_CNT  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [S_ADDR-1:0] i_pmem_address,
    input  logic [S_LINE-1:0] i_pmem_wdata,
    output logic [S_LINE-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [S_ADDR-1:0] d_pmem_address,
    input  logic [S_LINE-1:0] d_pmem_wdata,
    output logic [S_LINE-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [S_ADDR-1:0] pmem_address,
    output logic [S_LINE-1:0] pmem_wdata,
    input  logic [S_LINE-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              arbiter_instr_state,
    output logic              data_request,
    output logic [S_CNT-1:0]  perf_i_grants,
    output logic [S_CNT-1:0]  perf_d_grants,
    output logic [S_CNT-1:0]  perf_contention
);

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       i_req, d_req;

    assign i_req = i_pmem_read | i_pmem_write;
    assign d_req = d_pmem_read | d_pmem_write;

    // On a response the other client is served next if waiting; the finishing
    // client always passes through IDLE, since its request is still high here.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    state_d = (last_grant_q == GRANT_DATA) ? INSTR : DATA;
                end else if (i_req) begin
                    state_d = INSTR;
                end else if (d_req) begin
                    state_d = DATA;
                end
            end
            INSTR: begin
                if (pmem_resp) state_d = d_req ? DATA : IDLE;
            end
            DATA: begin
                if (pmem_resp) state_d = i_req ? INSTR : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if ((state_d == INSTR) && (state_q != INSTR)) last_grant_d = GRANT_INSTR;
        if ((state_d == DATA) && (state_q != DATA)) last_grant_d = GRANT_DATA;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_DATA;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign pmem_read    = ((state_q == INSTR) & i_pmem_read) | ((state_q == DATA) & d_pmem_read);
    assign pmem_write   = ((state_q == INSTR) & i_pmem_write) | ((state_q == DATA) & d_pmem_write);
    assign pmem_address = (state_q == DATA) ? d_pmem_address : i_pmem_address;
    assign pmem_wdata   = (state_q == DATA) ? d_pmem_wdata : i_pmem_wdata;

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign i_pmem_resp  = pmem_resp & (state_q == INSTR);
    assign d_pmem_resp  = pmem_resp & (state_q == DATA);

    assign arbiter_instr_state = (state_q == INSTR);
    assign data_request        = d_req;

`ifdef CACHE_ARB_PERF_EN
    logic i_enter, d_enter, contention;

    assign i_enter    = (state_d == INSTR) && (state_q != INSTR);
    assign d_enter    = (state_d == DATA) && (state_q != DATA);
    assign contention = ((state_q == INSTR) && d_req) ||
                        ((state_q == DATA) && i_req) ||
                        ((state_q == IDLE) && i_req && d_req);

    cache_arbiter_perf #(
        .S_CNT (S_CNT)
    ) u_perf (
        .clk               (clk),
        .rst               (rst),
        .i_grant_i         (i_enter),
        .d_grant_i         (d_enter),
        .contention_i      (contention),
        .perf_i_grants_o   (perf_i_grants),
        .perf_d_grants_o   (perf_d_grants),
        .perf_contention_o (perf_contention)
    );
`else
    assign perf_i_grants   = '0;
    assign perf_d_grants   = '0;
    assign perf_contention = '0;
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed scoreboard bench for cache_arbiter
module tb_cache_arbiter;

    localparam int S_LINE = 256;
    localparam int S_ADDR = 32;
    localparam int S_CNT  = 4;
`ifdef CACHE_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_pmem_read = 1'b0, i_pmem_write = 1'b0;
    logic [S_ADDR-1:0] i_pmem_address = '0;
    logic [S_LINE-1:0] i_pmem_wdata = '0;
    logic [S_LINE-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read = 1'b0, d_pmem_write = 1'b0;
    logic [S_ADDR-1:0] d_pmem_address = '0;
    logic [S_LINE-1:0] d_pmem_wdata = '0;
    logic [S_LINE-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              pmem_read, pmem_write;
    logic [S_ADDR-1:0] pmem_address;
    logic [S_LINE-1:0] pmem_wdata;
    logic [S_LINE-1:0] pmem_rdata = '0;
    logic              pmem_resp = 1'b0;
    logic              arbiter_instr_state, data_request;
    logic [S_CNT-1:0]  perf_i_grants, perf_d_grants, perf_contention;

    cache_arbiter #(.S_LINE(S_LINE), .S_ADDR(S_ADDR), .S_CNT(S_CNT)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
        .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .arbiter_instr_state(arbiter_instr_state), .data_request(data_request),
        .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
        .perf_contention(perf_contention)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [255:0] wdata;
    } txn_t;

    txn_t sb[$];
    int   n_pass = 0, n_fail = 0, n_total = 0;
    int   mem_lat = 4;
    int   mem_cnt = 0;
    logic i_drop = 1'b0, d_drop = 1'b0;

    function automatic logic [255:0] line_of(input logic [31:0] a);
        if (a == 32'h0000_0060) return {32{8'hA5}};
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    // Cacheline adaptor model: responds in the mem_lat-th cycle of a request.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pmem_resp = 1'b0;
            mem_cnt   = 0;
        end else begin
            #1;
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                mem_cnt   = 0;
            end
            if (rst && (pmem_read || pmem_write)) begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = line_of(pmem_address);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req_i(input logic we, input logic [31:0] a, input logic [255:0] wd);
        txn_t t;
        i_pmem_read = ~we; i_pmem_write = we; i_pmem_address = a; i_pmem_wdata = wd;
        t.is_d = 1'b0; t.we = we; t.addr = a; t.wdata = wd;
        sb.push_back(t);
    endtask

    task automatic req_d(input logic we, input logic [31:0] a, input logic [255:0] wd);
        txn_t t;
        d_pmem_read = ~we; d_pmem_write = we; d_pmem_address = a; d_pmem_wdata = wd;
        t.is_d = 1'b1; t.we = we; t.addr = a; t.wdata = wd;
        sb.push_back(t);
    endtask

    task automatic look();
        txn_t t;
        @(negedge clk);
        assert (!(i_pmem_read && i_pmem_write) && !(d_pmem_read && d_pmem_write))
        else $error("client drove read and write together");
        if (i_pmem_resp || d_pmem_resp) begin
            chk("resp_onehot", i_pmem_resp & d_pmem_resp, 1'b0);
            chk("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                t = sb.pop_front();
                chk("sb_client", d_pmem_resp, t.is_d);
                chk("sb_addr", pmem_address, t.addr);
                chk("sb_we", pmem_write, t.we);
                if (t.we) chk("sb_wdata", pmem_wdata, t.wdata);
                else chk("sb_rdata", t.is_d ? d_pmem_rdata : i_pmem_rdata, line_of(t.addr));
            end
            if (i_pmem_resp) i_drop = 1'b1;
            if (d_pmem_resp) d_drop = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (i_drop) begin i_pmem_read = 1'b0; i_pmem_write = 1'b0; i_drop = 1'b0; end
        if (d_drop) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_drop = 1'b0; end
    endtask

    task automatic wait_idle(input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            look();
            done = (sb.size() == 0) && !i_pmem_read && !i_pmem_write &&
                   !d_pmem_read && !d_pmem_write && !pmem_read && !pmem_write;
            tick();
        end
        chk("idle_reached", done, 1'b1);
    endtask

    task automatic clear_clients();
        i_pmem_read = 1'b0; i_pmem_write = 1'b0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        i_drop = 1'b0; d_drop = 1'b0;
        sb.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pmem_read"}, pmem_read, 1'b0);
        chk({tag, "_pmem_write"}, pmem_write, 1'b0);
        chk({tag, "_i_resp"}, i_pmem_resp, 1'b0);
        chk({tag, "_d_resp"}, d_pmem_resp, 1'b0);
        chk({tag, "_instr_state"}, arbiter_instr_state, 1'b0);
        chk({tag, "_perf_i"}, perf_i_grants, 4'd0);
        chk({tag, "_perf_d"}, perf_d_grants, 4'd0);
        chk({tag, "_perf_c"}, perf_contention, 4'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_clients();
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Lone instruction read, 4-cycle adaptor latency
        do_reset();
        mem_lat = 4;
        req_i(1'b0, 32'h0000_0060, '0);
        for (int c = 0; c <= 5; c++) begin
            look();
            chk("t1_instr_state", arbiter_instr_state, (c >= 1 && c <= 4));
            chk("t1_pmem_read", pmem_read, (c >= 1 && c <= 4));
            chk("t1_i_resp", i_pmem_resp, (c == 4));
            chk("t1_d_resp", d_pmem_resp, 1'b0);
            chk("t1_data_request", data_request, 1'b0);
            tick();
        end

        // Simultaneous reads after reset: instruction first, zero-bubble switch
        do_reset();
        mem_lat = 3;
        req_i(1'b0, 32'h0000_0100, '0);
        req_d(1'b0, 32'h0000_0200, '0);
        for (int c = 0; c <= 4; c++) begin
            look();
            if (c < 4) begin
                chk("t2_instr_state", arbiter_instr_state, (c >= 1));
            end else begin
                chk("t2_switch_instr_state", arbiter_instr_state, 1'b0);
                chk("t2_switch_pmem_read", pmem_read, 1'b1);
                chk("t2_switch_addr", pmem_address, 32'h0000_0200);
            end
            tick();
        end
        wait_idle(30);
        chk("t2_perf_contention", perf_contention, PERF ? 4'd4 : 4'd0);
        chk("t2_perf_i", perf_i_grants, PERF ? 4'd1 : 4'd0);
        chk("t2_perf_d", perf_d_grants, PERF ? 4'd1 : 4'd0);

        // Data-side writeback
        mem_lat = 2;
        req_d(1'b1, 32'h0000_1000, {8{32'h1234_5678}});
        for (int c = 0; c <= 3; c++) begin
            look();
            chk("t3_pmem_write", pmem_write, (c == 1 || c == 2));
            chk("t3_pmem_read", pmem_read, 1'b0);
            chk("t3_i_resp", i_pmem_resp, 1'b0);
            chk("t3_data_request", data_request, (c <= 2));
            if (c == 1 || c == 2) begin
                chk("t3_addr", pmem_address, 32'h0000_1000);
                chk("t3_wdata", pmem_wdata, {8{32'h1234_5678}});
            end
            tick();
        end
        wait_idle(10);

        // Two rounds of simultaneous requests: I, D, I, D
        do_reset();
        mem_lat = 2;
        for (int r = 0; r < 2; r++) begin
            req_i(1'b0, 32'h0000_2000 + 32'(r * 64), '0);
            req_d(1'b0, 32'h0000_3000 + 32'(r * 64), '0);
            wait_idle(40);
        end
        chk("t4_perf_i", perf_i_grants, PERF ? 4'd2 : 4'd0);
        chk("t4_perf_d", perf_d_grants, PERF ? 4'd2 : 4'd0);

        // Reset in the middle of a data transaction with an instruction request pending
        mem_lat = 10;
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_0300;
        look();
        tick();
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0400;
        look();
        tick();
        look();
        chk("t5_pre_instr_state", arbiter_instr_state, 1'b0);
        chk("t5_pre_pmem_read", pmem_read, 1'b1);
        chk("t5_pre_addr", pmem_address, 32'h0000_0300);
        rst = 1'b0;
        d_pmem_read = 1'b0;
        #1;
        chk_reset_outputs("t5_midreset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_lat = 3;
        begin
            txn_t t;
            t.is_d = 1'b0; t.we = 1'b0; t.addr = 32'h0000_0400; t.wdata = '0;
            sb.push_back(t);
        end
        look();
        chk("t5_post_idle", arbiter_instr_state, 1'b0);
        tick();
        look();
        chk("t5_post_granted", arbiter_instr_state, 1'b1);
        tick();
        wait_idle(20);

        // Saturation of the instruction grant counter at 4 bits
        mem_lat = 1;
        for (int k = 0; k < 20; k++) begin
            req_i(1'b0, 32'h0000_4000 + 32'(k * 32), '0);
            wait_idle(10);
        end
        chk("t6_perf_i_sat", perf_i_grants, PERF ? 4'd15 : 4'd0);
        chk("t6_perf_d", perf_d_grants, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
